// File: rtl/mem_arbiter.sv
// Owner of the byte-wide RAM/IO port: arbitrates fetch vs load/store, serialises each
// request into byte beats and returns assembled 32-bit data with a one-cycle done pulse.
module mem_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        clear,
    input  logic        if_sig,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_sig,
    input  logic        load_or_store,
    input  logic [2:0]  len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] store_val,
    output logic        ls_done,
    output logic [31:0] ls_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      r_state, w_state_next;
    logic        r_owner_ls, w_owner_ls_next;
    logic        r_last_ls, w_last_ls_next;
    logic        r_io, w_io_next;
    logic [31:0] r_base, w_base_next;
    logic [2:0]  r_n, w_n_next;
    logic [2:0]  r_k, w_k_next;
    logic [31:0] r_asm, w_asm_next;
    logic [31:0] r_store, w_store_next;
    logic [31:0] r_mem_a, w_mem_a_next;
    logic [7:0]  r_mem_dout, w_mem_dout_next;
    logic        r_mem_wr, w_mem_wr_next;
    logic        r_if_done, w_if_done_next;
    logic        r_ls_done, w_ls_done_next;
    logic [31:0] r_if_data, w_if_data_next;
    logic [31:0] r_ls_data, w_ls_data_next;

    logic        w_if_req;
    logic        w_grant_ls;
    logic [31:0] w_req_addr;
    logic [2:0]  w_k_inc;
    logic [31:0] w_beat_addr;
    logic [7:0]  w_next_byte;
    logic        w_stall;
    logic        w_ls_is_io;

    // A fetch is never started while the pipeline is being flushed.
    assign w_if_req    = if_sig & ~clear;
    assign w_grant_ls  = ls_sig & (~w_if_req | ~r_last_ls);
    assign w_req_addr  = w_grant_ls ? ls_addr : if_addr;
    assign w_k_inc     = r_k + 3'd1;
    assign w_beat_addr = r_base + {29'd0, w_k_inc};
    assign w_stall     = r_io & io_buffer_full;
    assign w_ls_is_io  = (ls_addr >= IO_BASE);

    always_comb begin
        case (w_k_inc)
            3'd1:    w_next_byte = r_store[15:8];
            3'd2:    w_next_byte = r_store[23:16];
            3'd3:    w_next_byte = r_store[31:24];
            default: w_next_byte = r_store[7:0];
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_owner_ls_next = r_owner_ls;
        w_last_ls_next  = r_last_ls;
        w_io_next       = r_io;
        w_base_next     = r_base;
        w_n_next        = r_n;
        w_k_next        = r_k;
        w_asm_next      = r_asm;
        w_store_next    = r_store;
        w_mem_a_next    = r_mem_a;
        w_mem_dout_next = r_mem_dout;
        w_mem_wr_next   = r_mem_wr;
        w_if_done_next  = 1'b0;
        w_ls_done_next  = 1'b0;
        w_if_data_next  = r_if_data;
        w_ls_data_next  = r_ls_data;

        case (r_state)
            IDLE: begin
                w_mem_wr_next = 1'b0;
                // Skip the cycle a done is visible so the requester can drop its sig.
                if (!(r_if_done | r_ls_done) && (w_if_req || ls_sig)) begin
                    w_owner_ls_next = w_grant_ls;
                    w_last_ls_next  = w_grant_ls;
                    w_base_next     = w_req_addr;
                    w_mem_a_next    = w_req_addr;
                    w_k_next        = 3'd0;
                    w_asm_next      = 32'd0;
                    if (w_grant_ls && load_or_store) begin
                        w_n_next        = len;
                        w_store_next    = store_val;
                        w_io_next       = w_ls_is_io;
                        w_mem_dout_next = store_val[7:0];
                        w_mem_wr_next   = ~(w_ls_is_io & io_buffer_full);
                        w_state_next    = WRITE;
                    end else begin
                        w_n_next     = w_grant_ls ? len : 3'd4;
                        w_state_next = READ;
                    end
                end
            end
            READ: begin
                if (clear) begin
                    w_state_next = IDLE;
                end else begin
                    // Byte k-1 arrives one cycle after its address was driven.
                    for (int b = 0; b < 4; b++) begin
                        if (r_k == 3'(b + 1)) w_asm_next[8*b +: 8] = mem_din;
                    end
                    if (r_k == r_n) begin
                        w_state_next = IDLE;
                        if (r_owner_ls) begin
                            w_ls_done_next = 1'b1;
                            w_ls_data_next = w_asm_next;
                        end else begin
                            w_if_done_next = 1'b1;
                            w_if_data_next = w_asm_next;
                        end
                    end else begin
                        w_k_next = w_k_inc;
                        if (w_k_inc < r_n) w_mem_a_next = w_beat_addr;
                    end
                end
            end
            WRITE: begin
                if (r_mem_wr) begin
                    if (w_k_inc == r_n) begin
                        w_mem_wr_next  = 1'b0;
                        w_ls_done_next = 1'b1;
                        w_state_next   = IDLE;
                    end else begin
                        w_k_next        = w_k_inc;
                        w_mem_a_next    = w_beat_addr;
                        w_mem_dout_next = w_next_byte;
                        w_mem_wr_next   = ~w_stall;
                    end
                end else begin
                    // Stalled beat: address and data are already on the bus.
                    w_mem_wr_next = ~w_stall;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner_ls <= 1'b0;
            r_last_ls  <= 1'b0;
            r_io       <= 1'b0;
            r_base     <= 32'd0;
            r_n        <= 3'd0;
            r_k        <= 3'd0;
            r_asm      <= 32'd0;
            r_store    <= 32'd0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= 32'd0;
            r_ls_data  <= 32'd0;
        end else if (rdy) begin
            r_state    <= w_state_next;
            r_owner_ls <= w_owner_ls_next;
            r_last_ls  <= w_last_ls_next;
            r_io       <= w_io_next;
            r_base     <= w_base_next;
            r_n        <= w_n_next;
            r_k        <= w_k_next;
            r_asm      <= w_asm_next;
            r_store    <= w_store_next;
            r_mem_a    <= w_mem_a_next;
            r_mem_dout <= w_mem_dout_next;
            r_mem_wr   <= w_mem_wr_next;
            r_if_done  <= w_if_done_next;
            r_ls_done  <= w_ls_done_next;
            r_if_data  <= w_if_data_next;
            r_ls_data  <= w_ls_data_next;
        end
    end

    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign mem_wr   = r_mem_wr;
    assign if_done  = r_if_done;
    assign if_data  = r_if_data;
    assign ls_done  = r_ls_done;
    assign ls_data  = r_ls_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte-addressed reference memory predicts every
// returned word and every write beat; a negedge monitor pops and compares.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, io_buffer_full, clear;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_sig, if_done, ls_sig, load_or_store, ls_done;
    logic [31:0] if_addr, if_data, ls_addr, store_val, ls_data;
    logic [2:0]  len;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .clear(clear),
        .if_sig(if_sig), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_sig(ls_sig), .load_or_store(load_or_store), .len(len), .ls_addr(ls_addr),
        .store_val(store_val), .ls_done(ls_done), .ls_data(ls_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Memory: bus_mem is what the DUT writes/reads, ref_mem is the bench's prediction.
    logic [7:0] bus_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] def_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C ^ {a[1:0], a[31:26]};
    endfunction
    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return def_byte(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return def_byte(a);
    endfunction
    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[8*i +: 8] = ref_rd(a + 32'(i));
        return d;
    endfunction
    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        bus_mem[a] = b;
        ref_mem[a] = b;
    endtask

    logic [31:0] a_prev = 32'd0;
    always @(negedge clk) begin
        if (mem_wr && rdy && !rst) bus_mem[mem_a] = mem_dout;
        a_prev = mem_a;
    end
    always @(posedge clk) begin
        #1;
        mem_din = bus_rd(a_prev);
    end

    // Scoreboard queues and monitor.
    logic [31:0] exp_if[$];
    bit          exp_ls_load[$];
    logic [31:0] exp_ls_data[$];
    logic [39:0] exp_wr[$];
    bit          done_log[$];
    int          wr_log[$];
    logic [31:0] a_hist [int];
    int          n_if_done = 0;
    int          n_ls_done = 0;

    always @(negedge clk) begin
        a_hist[cyc] = mem_a;
        if (!rst) begin
            if (if_done) begin
                n_if_done++;
                done_log.push_back(1'b0);
                if (exp_if.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL if_done_unexpected: got if_data %0h expected no done", if_data);
                end else check("if_data", if_data, exp_if.pop_front());
            end
            if (ls_done) begin
                n_ls_done++;
                done_log.push_back(1'b1);
                if (exp_ls_load.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL ls_done_unexpected: got ls_data %0h expected no done", ls_data);
                end else begin
                    bit ld;
                    logic [31:0] d;
                    ld = exp_ls_load.pop_front();
                    d  = exp_ls_data.pop_front();
                    if (ld) check("ls_data", ls_data, d);
                end
            end
            if (mem_wr && rdy) begin
                wr_log.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL wr_unexpected: got beat %0h:%0h expected none", mem_a, mem_dout);
                end else check("wr_beat", {mem_a, mem_dout}, exp_wr.pop_front());
            end
        end
    end

    task automatic issue_if(input logic [31:0] a, input bit expect_it);
        if (expect_it) exp_if.push_back(ref_word(a, 4));
        if_addr = a;
        if_sig  = 1'b1;
    endtask

    task automatic issue_ls(input bit st, input logic [2:0] l, input logic [31:0] a,
                            input logic [31:0] v, input bit expect_it);
        if (expect_it) begin
            exp_ls_load.push_back(!st);
            if (st) begin
                for (int i = 0; i < int'(l); i++) begin
                    logic [31:0] ai;
                    ai = a + 32'(i);
                    exp_wr.push_back({ai, v[8*i +: 8]});
                    ref_mem[ai] = v[8*i +: 8];
                end
                exp_ls_data.push_back(32'd0);
            end else exp_ls_data.push_back(ref_word(a, int'(l)));
        end
        load_or_store = st;
        len           = l;
        ls_addr       = a;
        store_val     = v;
        ls_sig        = 1'b1;
    endtask

    task automatic wait_if(output int dc);
        int b;
        b  = 0;
        dc = -1;
        while (b < 200) begin
            @(negedge clk);
            b++;
            if (if_done) begin dc = cyc; break; end
        end
        if (dc < 0) begin
            vectors++; miscompares++;
            $display("FAIL if_done_timeout: got no done expected done within 200 cycles");
        end
        @(posedge clk); #1;
        if_sig = 1'b0;
    endtask

    task automatic wait_ls(output int dc);
        int b;
        b  = 0;
        dc = -1;
        while (b < 200) begin
            @(negedge clk);
            b++;
            if (ls_done) begin dc = cyc; break; end
        end
        if (dc < 0) begin
            vectors++; miscompares++;
            $display("FAIL ls_done_timeout: got no done expected done within 200 cycles");
        end
        @(posedge clk); #1;
        ls_sig = 1'b0;
    endtask

    task automatic rand_ls();
        int r;
        logic [2:0] l;
        r = $urandom_range(0, 2);
        l = (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : 3'b100;
        r = $urandom_range(0, 3);
        if (r < 2)       issue_ls(1'b0, l, 32'($urandom_range(0, 32'h1FFC)), 32'd0, 1'b1);
        else if (r == 2) issue_ls(1'b1, l, 32'h1000 + 32'($urandom_range(0, 32'hFF0)), $urandom, 1'b1);
        else             issue_ls(1'b1, l, 32'h0003_0000 + 32'($urandom_range(0, 255)), $urandom, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_a"}, mem_a, 32'd0);
        check({tag, "_mem_dout"}, mem_dout, 8'd0);
        check({tag, "_mem_wr"}, mem_wr, 1'b0);
        check({tag, "_if_done"}, if_done, 1'b0);
        check({tag, "_ls_done"}, ls_done, 1'b0);
        check({tag, "_if_data"}, if_data, 32'd0);
        check({tag, "_ls_data"}, ls_data, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300us");
        $fatal(1);
    end

    initial begin
        int st, dc, n0, base;
        bit if_fin, ls_fin;
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
        if_sig = 1'b0; if_addr = 32'd0; ls_sig = 1'b0; load_or_store = 1'b0;
        len = 3'b001; ls_addr = 32'd0; store_val = 32'd0; mem_din = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Fetch at 0x100, then an immediate re-request after the cooldown cycle.
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        @(posedge clk); #1;
        st = cyc;
        issue_if(32'h100, 1'b1);
        wait_if(dc);
        check("fetch_latency", dc, st + 6);
        check("fetch_word", if_data, 32'h0000_0513);
        for (int k = 0; k < 4; k++) check("fetch_addr_walk", a_hist[st + 1 + k], 32'h100 + 32'(k));
        st = cyc;
        issue_if(32'h104, 1'b1);
        wait_if(dc);
        check("refetch_latency", dc, st + 6);

        // Byte and halfword loads.
        poke(32'h200, 8'hF0); poke(32'h201, 8'h34); poke(32'h202, 8'h12);
        st = cyc;
        issue_ls(1'b0, 3'b001, 32'h200, 32'd0, 1'b1);
        wait_ls(dc);
        check("lb_latency", dc, st + 3);
        st = cyc;
        issue_ls(1'b0, 3'b010, 32'h201, 32'd0, 1'b1);
        wait_ls(dc);
        check("lh_latency", dc, st + 4);
        check("lh_data", ls_data, 32'h0000_1234);

        // Word store then read it back.
        base = wr_log.size();
        st = cyc;
        issue_ls(1'b1, 3'b100, 32'h1000, 32'hDEAD_BEEF, 1'b1);
        wait_ls(dc);
        check("sw_latency", dc, st + 5);
        check("sw_beats", wr_log.size() - base, 4);
        check("sw_first_beat", wr_log[base], st + 1);
        issue_ls(1'b0, 3'b100, 32'h1000, 32'd0, 1'b1);
        wait_ls(dc);

        // IO store with the sink full for three cycles.
        base = wr_log.size();
        st = cyc;
        io_buffer_full = 1'b1;
        issue_ls(1'b1, 3'b001, 32'h0003_0000, 32'h0000_0055, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        io_buffer_full = 1'b0;
        wait_ls(dc);
        check("io_beats", wr_log.size() - base, 1);
        check("io_beat_cycle", wr_log[base], st + 4);
        check("io_done_latency", dc, st + 5);

        // Flush a fetch at beat index 2: no done, arbiter idle afterwards.
        n0 = n_if_done;
        st = cyc;
        issue_if(32'h400, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("flush_k2_addr", mem_a, 32'h402);
        clear = 1'b1; if_sig = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("flush_no_if_done", n_if_done, n0);
        st = cyc;
        issue_ls(1'b0, 3'b001, 32'h200, 32'd0, 1'b1);
        wait_ls(dc);
        check("after_flush_latency", dc, st + 3);

        // Flush during a store does not abort it.
        base = wr_log.size();
        st = cyc;
        issue_ls(1'b1, 3'b100, 32'h1010, 32'hA5B6_C7D8, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        wait_ls(dc);
        check("clear_store_latency", dc, st + 5);
        check("clear_store_beats", wr_log.size() - base, 4);

        // rdy low during beat 1 repeats that beat.
        base = wr_log.size();
        st = cyc;
        issue_ls(1'b1, 3'b100, 32'h1020, 32'h0102_0304, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        rdy = 1'b0;
        @(posedge clk); #1;
        rdy = 1'b1;
        wait_ls(dc);
        check("rdy_store_latency", dc, st + 6);
        check("rdy_store_beats", wr_log.size() - base, 4);

        // 32-bit address wrap.
        st = cyc;
        issue_if(32'hFFFF_FFFE, 1'b1);
        wait_if(dc);
        check("wrap_latency", dc, st + 6);

        // Reset in the middle of a load.
        n0 = n_ls_done;
        issue_ls(1'b0, 3'b100, 32'h300, 32'd0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; ls_sig = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (8) @(posedge clk);
        check("midrst_no_ls_done", n_ls_done, n0);

        // Contention with immediate re-requests: grants alternate LS, IF, LS, IF.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        base = done_log.size();
        if_fin = 1'b0; ls_fin = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int d;
                    issue_if(32'($urandom_range(0, 32'hFF0)), 1'b1);
                    wait_if(d);
                end
                if_fin = 1'b1;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    int d;
                    rand_ls();
                    wait_ls(d);
                end
                ls_fin = 1'b1;
            end
            begin
                while (!(if_fin && ls_fin)) begin
                    @(posedge clk); #1;
                    io_buffer_full = ($urandom_range(0, 3) == 0);
                end
                io_buffer_full = 1'b0;
            end
        join
        check("alt_done_count", done_log.size() - base, 12);
        for (int i = 0; i < 12; i++) begin
            if (base + i < done_log.size())
                check("alt_grant_order", done_log[base + i], (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Random requests with random gaps.
        if_fin = 1'b0; ls_fin = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    int d;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    issue_if(32'($urandom_range(0, 32'hFF0)), 1'b1);
                    wait_if(d);
                end
                if_fin = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    int d;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    rand_ls();
                    wait_ls(d);
                end
                ls_fin = 1'b1;
            end
            begin
                while (!(if_fin && ls_fin)) begin
                    @(posedge clk); #1;
                    io_buffer_full = ($urandom_range(0, 3) == 0);
                end
                io_buffer_full = 1'b0;
            end
        join

        repeat (5) @(posedge clk);
        check("if_queue_drained", exp_if.size(), 0);
        check("ls_queue_drained", exp_ls_load.size(), 0);
        check("wr_queue_drained", exp_wr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the 8-bit unified RAM/IO port. Arbitrates between instruction fetch (fixed 4-byte reads) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each request into byte beats and assembles/returns 32-bit data with a one-cycle done pulse.
- Sits between ifetch/lsBuffer and the top-level memory pins. Handles pipeline flush and IO back-pressure.

Parameters:
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO. Stores there obey io_buffer_full.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; when low, all registers hold
- mem_din  in  8  RAM read data; valid the cycle after its address is driven
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write beat
- io_buffer_full  in  1  IO sink cannot accept a write
- clear  in  1  branch-mispredict flush
- if_sig  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction
- ls_sig  in  1  LSB request, level, held until ls_done
- load_or_store  in  1  0 load, 1 store
- len  in  3  byte count: 3'b001, 3'b010 or 3'b100 only
- ls_addr  in  32  LSB address
- store_val  in  32  store data
- ls_done  out  1  one-cycle pulse
- ls_data  out  32  load data, zero-extended

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state=IDLE; mem_a=0; mem_dout=0; mem_wr=0; if_done=0; ls_done=0; if_data=0; ls_data=0; last_grant=IF.
- All outputs are registered.
- States are IDLE, READ, WRITE.
  - Internal registers: owner (IF/LS), base address, byte count n, beat index k, 32-bit assembly register.
- IDLE:
  - A request is sampled only if done was not pulsed in the previous cycle (cooldown). This lets the requester drop sig.
  - Grant rule:
    - Only one requester active: grant it.
    - Both active: grant LS, unless last_grant==LS, in which case grant IF (alternating).
  - A fetch or load grant goes to READ with n=4 (IF) or n=len. A store goes to WRITE.
  - On grant: mem_a<=addr, k<=0, last_grant updated.
  - IF is not granted in a cycle where clear=1.
- READ:
  - Cycle A is the grant cycle. mem_a=addr+k is driven in cycles A+1..A+n.
  - Byte k is captured from mem_din in cycle A+2+k into data[8k+7:8k]. Upper unused bytes are 0.
  - After the last byte, return to IDLE and pulse done in cycle A+n+2, with data on if_data/ls_data.
  - The data output holds until the next done.
- WRITE:
  - Beat k drives mem_a=addr+k, mem_dout=store_val[8k+7:8k], mem_wr=1, in cycles A+1..A+n. Byte order is little-endian.
  - If addr>=IO_BASE and io_buffer_full=1, the beat stalls: mem_wr=0 and k holds until io_buffer_full=0.
  - ls_done pulses the cycle after the last beat (A+n+1 with no stalls). Then return to IDLE with mem_wr=0.
- clear:
  - An in-flight fetch, or a load granted to LS, is aborted that edge: go to IDLE with no done pulse and mem_wr=0.
  - An in-flight store is never aborted; it completes with ls_done.
  - A done pulse already scheduled for the same edge as clear is suppressed for IF and for loads.
- Address arithmetic is 32-bit wrap; addr+k may carry across any byte boundary.
- rdy=0: freeze state and all outputs. A beat in progress repeats when rdy returns; it is not skipped.
- Reset mid-transfer: immediate return to reset values. No done is emitted.
- len values outside the legal set are undefined; the bench must not drive them.

Test Plan:
- Fetch only: if_sig=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> mem_a walks 0x100..0x103; if_done pulses exactly 6 cycles after the grant cycle with if_data=0x00000513; one cooldown cycle before re-grant.
- Byte load vs halfword load: len=1 at 0x200 (RAM=0xF0) -> ls_data=0x000000F0 at A+3; len=2 at 0x201 -> ls_data={RAM[0x202],RAM[0x201]}, upper 16 bits 0.
- Store word to 0x1000, store_val=0xDEADBEEF -> mem_wr=1 for 4 cycles with mem_dout EF,BE,AD,DE at 0x1000..0x1003; ls_done at A+5.
- Contention: if_sig and ls_sig asserted continuously with re-requests -> grants alternate LS, IF, LS, IF; neither starves.
- IO store: len=1 to 0x30000, io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then exactly one write beat; ls_done follows.
- Flush: clear mid-fetch (k=2) -> no if_done, IDLE next cycle. Clear mid-store -> store completes all beats and ls_done still pulses. rst mid-load -> all outputs at reset values next cycle.
